debounce_tick: RTL

DEBOUNCE_TICK -- requirements
Module: debounce_tick

---
 rtl/debounce_tick_pkg.sv | 19 +
 rtl/debounce_tick_sync_2ff.sv | 21 ++
 rtl/debounce_tick.sv | 87 ++++++++
 3 files changed

// File: rtl/debounce_tick_pkg.sv
// Shared definitions for the switch debouncer: state encoding, default
// counter width and the debounced-level decode.
package debounce_tick_pkg;

   localparam int unsigned CNT_W_DEFAULT = 20;

   typedef enum logic [1:0] {
      ZERO  = 2'b00,
      WAIT1 = 2'b01,
      ONE   = 2'b10,
      WAIT0 = 2'b11
   } state_t;

   // Level is already 1 while confirming a fall; a bounce back keeps it there.
   function automatic logic is_level(input state_t s);
      return (s == ONE) || (s == WAIT0);
   endfunction

endpackage

// File: rtl/debounce_tick_sync_2ff.sv
// Two-flop synchronizer bringing the raw switch level into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/debounce_tick.sv
// Switch debouncer: synchronizes sw, requires 2^CNT_W stable cycles before
// changing level, and emits registered rise/fall pulses with the level change.
module debounce_tick
   import debounce_tick_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic sw,
   output logic db_level,
   output logic db_tick,
   output logic db_fall_tick
);

   localparam logic [CNT_W-1:0] Q_LOAD = '1;
   localparam logic [CNT_W-1:0] Q_STEP = {{(CNT_W-1){1'b0}}, 1'b1};

   logic           s2;
   state_t         state;
   state_t         state_nxt;
   logic [CNT_W-1:0] q;
   logic [CNT_W-1:0] q_nxt;
   logic           level_now;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sw),
      .q     (s2)
   );

   // Ticks are derived from the registered level so they line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ZERO;
         q            <= '0;
         db_level     <= 1'b0;
         db_tick      <= 1'b0;
         db_fall_tick <= 1'b0;
      end else begin
         state        <= state_nxt;
         q            <= q_nxt;
         db_level     <= level_now;
         db_tick      <= level_now & ~db_level;
         db_fall_tick <= ~level_now & db_level;
      end
   end

   always_comb begin
      state_nxt = state;
      q_nxt     = q;
      level_now = is_level(state);
      case (state)
         ZERO: begin
            if (s2) begin
               state_nxt = WAIT1;
               q_nxt     = Q_LOAD;
            end
         end
         WAIT1: begin
            if (!s2)
               state_nxt = ZERO;
            else if (q != '0)
               q_nxt = q - Q_STEP;
            else
               state_nxt = ONE;
         end
         ONE: begin
            if (!s2) begin
               state_nxt = WAIT0;
               q_nxt     = Q_LOAD;
            end
         end
         WAIT0: begin
            if (s2)
               state_nxt = ONE;
            else if (q != '0)
               q_nxt = q - Q_STEP;
            else
               state_nxt = ZERO;
         end
         default: state_nxt = ZERO;
      endcase
   end

endmodule
